// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: valid/ready word input with a one-word holding buffer,
// runtime baud divisor latched per frame, optional parity and one or two stop bits.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BAUD_DIV_W-1:0] baud_div,
  input  logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  state_q, state_d;
  logic [BAUD_DIV_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [BAUD_DIV_W-1:0]   baud_lat_q, baud_lat_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic                    bit_wrap, accept, load_en;
  logic [DATA_W-1:0]       load_word;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ 1'(PARITY_ODD);
  endfunction

  assign bit_wrap = (baud_cnt_q == baud_lat_q);
  assign accept   = tx_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = '0;
    baud_lat_d  = baud_lat_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    done_d      = 1'b0;
    load_en     = 1'b0;
    load_word   = tx_data;

    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_wrap ? '0 : baud_cnt_q + 1'b1;
      if (accept) begin
        hold_d      = tx_data;
        hold_full_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE:   if (tx_valid) load_en = 1'b1;
      S_START:  if (bit_wrap) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA:   if (bit_wrap) begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == LAST_DATA) begin
          bit_cnt_d = '0;
          state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_PARITY: if (bit_wrap) begin
        state_d   = S_STOP;
        bit_cnt_d = '0;
      end
      S_STOP:   if (bit_wrap) begin
        if (bit_cnt_q == LAST_STOP) begin
          done_d = 1'b1;
          // A held word wins over a word offered on this same edge
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (tx_valid) begin
            load_en     = 1'b1;
            hold_full_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase

    if (load_en) begin
      state_d    = S_START;
      shift_d    = load_word;
      par_d      = parity_of(load_word);
      baud_lat_d = baud_div;
      baud_cnt_d = '0;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    hold_q     <= hold_d;
    par_q      <= par_d;
    baud_lat_q <= baud_lat_d;
  end

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three configurations (8E1, 8N1, 8O2) sharing clk and rst.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] e1_div = 16'd3, n1_div = 16'd3, o2_div = 16'd0;
  logic [7:0]  e1_data = '0, n1_data = '0, o2_data = '0;
  logic        e1_valid = 1'b0, n1_valid = 1'b0, o2_valid = 1'b0;
  logic        e1_ready, e1_tx, e1_busy, e1_done;
  logic        n1_ready, n1_tx, n1_busy, n1_done;
  logic        o2_ready, o2_tx, o2_busy, o2_done;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_cfg #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .BAUD_DIV_W(16)) u_e1 (
    .clk(clk), .rst(rst), .baud_div(e1_div), .tx_data(e1_data), .tx_valid(e1_valid),
    .tx_ready(e1_ready), .tx(e1_tx), .tx_busy(e1_busy), .tx_done(e1_done));

  uart_tx_cfg #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .BAUD_DIV_W(16)) u_n1 (
    .clk(clk), .rst(rst), .baud_div(n1_div), .tx_data(n1_data), .tx_valid(n1_valid),
    .tx_ready(n1_ready), .tx(n1_tx), .tx_busy(n1_busy), .tx_done(n1_done));

  uart_tx_cfg #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .BAUD_DIV_W(16)) u_o2 (
    .clk(clk), .rst(rst), .baud_div(o2_div), .tx_data(o2_data), .tx_valid(o2_valid),
    .tx_ready(o2_ready), .tx(o2_tx), .tx_busy(o2_busy), .tx_done(o2_done));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived line sequences, one entry per bit period
  int bits_e1_a5[11] = '{0, 1,0,1,0,0,1,0,1, 0, 1};
  int bits_bb[20]    = '{0, 1,0,1,0,1,0,1,0, 1,  0, 1,1,1,1,0,0,0,0, 1};
  int bits_o2_00[12] = '{0, 0,0,0,0,0,0,0,0, 1, 1,1};
  int bits_div1[10]  = '{0, 1,1,0,0,1,1,0,0, 1};
  int bits_div2[10]  = '{0, 1,1,0,0,0,0,1,1, 1};
  int bits_bp[20]    = '{0, 1,0,0,0,0,0,0,1, 1,  0, 0,0,1,1,1,1,0,0, 1};

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_e1_tx", e1_tx, 1);       chk("rst_e1_ready", e1_ready, 1);
    chk("rst_e1_busy", e1_busy, 0);   chk("rst_e1_done", e1_done, 0);
    chk("rst_n1_tx", n1_tx, 1);       chk("rst_n1_ready", n1_ready, 1);
    chk("rst_n1_busy", n1_busy, 0);   chk("rst_n1_done", n1_done, 0);
    chk("rst_o2_tx", o2_tx, 1);       chk("rst_o2_ready", o2_ready, 1);
    chk("rst_o2_busy", o2_busy, 0);   chk("rst_o2_done", o2_done, 0);
    step();

    // 8E1, 0xA5, 4-cycle bits
    e1_data = 8'hA5; e1_valid = 1'b1;
    step();
    e1_valid = 1'b0;
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("e1_tx_k%0d", k), e1_tx, bits_e1_a5[k/4]);
      chk($sformatf("e1_ready_k%0d", k), e1_ready, 1);
      chk($sformatf("e1_done_k%0d", k), e1_done, 0);
      chk($sformatf("e1_busy_k%0d", k), e1_busy, 1);
      step();
    end
    chk("e1_done_end", e1_done, 1);
    chk("e1_tx_end", e1_tx, 1);
    chk("e1_busy_end", e1_busy, 0);
    step();
    chk("e1_done_after", e1_done, 0);

    // Back-to-back 8N1: 0x55 then 0x0F held
    n1_div = 16'd3; n1_data = 8'h55; n1_valid = 1'b1;
    step();
    n1_data = 8'h0F;
    for (int k = 0; k <= 80; k++) begin
      if (k == 1) n1_valid = 1'b0;
      chk($sformatf("bb_tx_k%0d", k), n1_tx, (k < 80) ? bits_bb[k/4] : 1);
      chk($sformatf("bb_ready_k%0d", k), n1_ready, (k >= 1 && k < 40) ? 0 : 1);
      chk($sformatf("bb_done_k%0d", k), n1_done, (k == 40 || k == 80) ? 1 : 0);
      step();
    end
    chk("bb_busy_end", n1_busy, 0);

    // 8O2, 0x00, one clock per bit
    o2_data = 8'h00; o2_valid = 1'b1;
    step();
    o2_valid = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("o2_tx_k%0d", k), o2_tx, (k < 12) ? bits_o2_00[k] : 1);
      chk($sformatf("o2_done_k%0d", k), o2_done, (k == 12) ? 1 : 0);
      step();
    end
    chk("o2_busy_end", o2_busy, 0);

    // Divisor change mid-frame: 0x33 at div 3, then held 0xC3 at div 7
    n1_div = 16'd3; n1_data = 8'h33; n1_valid = 1'b1;
    step();
    n1_data = 8'hC3;
    for (int k = 0; k <= 120; k++) begin
      if (k == 1) n1_valid = 1'b0;
      if (k == 10) n1_div = 16'd7;
      chk($sformatf("div_tx_k%0d", k), n1_tx,
          (k < 40) ? bits_div1[k/4] : (k < 120) ? bits_div2[(k-40)/8] : 1);
      chk($sformatf("div_done_k%0d", k), n1_done, (k == 40 || k == 120) ? 1 : 0);
      step();
    end
    n1_div = 16'd3;

    // Reset mid-frame with a word held
    n1_data = 8'hAA; n1_valid = 1'b1;
    step();
    n1_data = 8'h11;
    step();
    n1_valid = 1'b0;
    chk("rmf_held", n1_ready, 0);
    repeat (10) step();
    chk("rmf_in_frame", n1_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmf_tx", n1_tx, 1);
    chk("rmf_ready", n1_ready, 1);
    chk("rmf_busy", n1_busy, 0);
    chk("rmf_done", n1_done, 0);
    for (int k = 0; k < 60; k++) begin
      chk($sformatf("rmf_quiet_tx_k%0d", k), n1_tx, 1);
      chk($sformatf("rmf_quiet_done_k%0d", k), n1_done, 0);
      step();
    end

    // Reset wins over a simultaneous transfer
    e1_data = 8'h3C; e1_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; e1_valid = 1'b0;
    chk("rstpri_busy", e1_busy, 0);
    chk("rstpri_tx", e1_tx, 1);
    step();
    chk("rstpri_busy2", e1_busy, 0);

    // Back-pressure: tx_valid held high with changing data while the buffer is full
    n1_div = 16'd0; n1_data = 8'h81; n1_valid = 1'b1;
    step();
    n1_data = 8'h3C;
    for (int k = 0; k <= 21; k++) begin
      if (k == 1) n1_data = 8'hFF;
      if (k >= 2 && k < 10) n1_data = 8'(k * 8'h17);
      if (k == 10) n1_valid = 1'b0;
      if (k < 20) chk($sformatf("bp_tx_k%0d", k), n1_tx, bits_bp[k]);
      else        chk($sformatf("bp_tx_k%0d", k), n1_tx, 1);
      chk($sformatf("bp_ready_k%0d", k), n1_ready, (k >= 1 && k < 10) ? 0 : 1);
      chk($sformatf("bp_done_k%0d", k), n1_done, (k == 10 || k == 20) ? 1 : 0);
      step();
    end
    chk("bp_idle", n1_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
